mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ADDR_BASE, default 32'd1024, byte address mapped to data-memory word 0.
REQ-002 Parameter ADDR_W, default 6, word-address width of the data memory (64 words).
REQ-003 clk  input  1  rising-edge clock; the block has one clock.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 wb_en_in, mem_read_in, mem_write_in  input  1 each  control bits from the EXE stage register.
REQ-006 ALU_result_in  input  32  byte address for loads and stores; write-back value for non-loads.
REQ-007 valRm_in  input  32  store data.
REQ-008 dest_in  input  4  destination register.
REQ-009 mem_req  output  1  memory request; held high until mem_ack.
REQ-010 mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
REQ-011 mem_addr  output  ADDR_W  word address.
REQ-012 mem_wdata  output  32  store data.
REQ-013 mem_rdata  input  32  read data; valid in the mem_ack cycle.
REQ-014 mem_ack  input  1  single-cycle completion pulse.
REQ-015 freeze  output  1  upstream hold; the EXE register and earlier stages do not advance while it is high.
REQ-016 wb_en, mem_read  output  1 each  registered control bits to WB.
REQ-017 ALU_result, mem_data  output  32 each  registered ALU result and load data to WB.
REQ-018 dest  output  4  registered destination register.

Function
REQ-019 FSM states: IDLE, WAIT, DONE.
REQ-020 IDLE, mem_read_in|mem_write_in=1 -> freeze=1 combinationally; latch mem_we=mem_write_in, mem_addr=(ALU_result_in-ADDR_BASE)>>2 truncated to ADDR_W, mem_wdata=valRm_in; set mem_req=1; go to WAIT.
REQ-021 WAIT: freeze=1; mem_ack=0 -> stay; mem_ack=1 -> capture mem_rdata into a hold register, clear mem_req, go to DONE.
REQ-022 DONE: freeze=0; load output register from the held inputs plus captured read data (mem_data only for loads; stores set mem_data=0); go to IDLE.
REQ-023 Output register loads a bubble (wb_en=0, mem_read=0, dest=0, data 0) on every edge where freeze=1.
REQ-024 Non-memory instruction in IDLE: freeze=0; output register loads the inputs next edge (1-cycle latency); mem_data=0.
REQ-025 Memory access with ack in the first WAIT cycle: 3 cycles from presentation to output; each extra ack wait adds 1 cycle.
REQ-026 Back-to-back memory instructions: the second is detected in IDLE on the cycle after DONE; no overlap.
REQ-027 mem_ack in IDLE or DONE is ignored.
REQ-028 mem_addr, mem_we and mem_wdata stay stable from request to ack.
REQ-029 Address subtraction wraps modulo 2^32; bits [1:0] are ignored.

Reset
REQ-030 rst low (any time, including mid-WAIT): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, freeze=0; all output-register fields 0; any pending access is abandoned.
REQ-031 After rst release, a late mem_ack is ignored.

Configuration
REQ-032 Macro MEM_RANGE_CHECK_EN defined: an access with (ALU_result_in-ADDR_BASE) >= 4*2^ADDR_W issues no request, takes IDLE->DONE with freeze=1 for 1 cycle, and returns mem_data=0 (stores dropped).
REQ-033 Macro undefined: no range check; the address is truncated per REQ-020.

Structure
REQ-034 Shared package arm_pkg holds the FSM state enum (mem_state_t) and the ADDR_BASE default constant.
REQ-035 The output pipeline register is the sub-module mem_wb_reg (async active-low reset, load/bubble select); FSM and memory interface are in mem_stage.

Verification
REQ-036 ADD: wb_en_in=1, ALU_result_in=0x55, dest_in=3 -> next cycle wb_en=1, ALU_result=0x55, dest=3; freeze never high.
REQ-037 LDR: ALU_result_in=1028, ack 2 cycles after mem_req, mem_rdata=0xDEADBEEF -> mem_addr=1, freeze high 3 cycles, then mem_read=1, mem_data=0xDEADBEEF, wb_en=1.
REQ-038 STR: ALU_result_in=1032, valRm_in=0x12345678, immediate ack -> mem_we=1, mem_addr=2, mem_wdata=0x12345678; freeze high 2 cycles; output wb_en=0.
REQ-039 rst low during WAIT -> mem_req=0 and freeze=0 immediately; mem_ack after release causes no output change.
REQ-040 MEM_RANGE_CHECK_EN, LDR at 1024+256 -> no mem_req, freeze high 1 cycle, mem_data=0; without the macro, mem_addr=0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package arm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } mem_state_t;

  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;

  // Word offset from the base; the subtraction wraps and the byte lane is dropped.
  function automatic logic [29:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] diff;
    diff = addr - base;
    return diff[31:2];
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads the presented fields, or a bubble when load is low.
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        wb_en_in,
  input  logic        mem_read_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] mem_data_in,
  input  logic [3:0]  dest_in,
  output logic        wb_en,
  output logic        mem_read,
  output logic [31:0] ALU_result,
  output logic [31:0] mem_data,
  output logic [3:0]  dest
);

  logic        wb_en_q, wb_en_d;
  logic        mem_read_q, mem_read_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [3:0]  dest_q, dest_d;

  always_comb begin
    wb_en_d    = 1'b0;
    mem_read_d = 1'b0;
    alu_d      = '0;
    mem_data_d = '0;
    dest_d     = '0;
    if (load) begin
      wb_en_d    = wb_en_in;
      mem_read_d = mem_read_in;
      alu_d      = alu_in;
      mem_data_d = mem_data_in;
      dest_d     = dest_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      mem_read_q <= 1'b0;
      alu_q      <= '0;
      mem_data_q <= '0;
      dest_q     <= '0;
    end else begin
      wb_en_q    <= wb_en_d;
      mem_read_q <= mem_read_d;
      alu_q      <= alu_d;
      mem_data_q <= mem_data_d;
      dest_q     <= dest_d;
    end
  end

  assign wb_en      = wb_en_q;
  assign mem_read   = mem_read_q;
  assign ALU_result = alu_q;
  assign mem_data   = mem_data_q;
  assign dest       = dest_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: req/ack data-memory handshake, upstream freeze and MEM/WB register.
// Define MEM_RANGE_CHECK_EN to drop accesses that fall beyond the data memory.
module mem_stage
  import arm_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEFAULT,
  parameter int          ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [31:0]       ALU_result_in,
  input  logic [31:0]       valRm_in,
  input  logic [3:0]        dest_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              freeze,
  output logic              wb_en,
  output logic              mem_read,
  output logic [31:0]       ALU_result,
  output logic [31:0]       mem_data,
  output logic [3:0]        dest
);

  mem_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              hold_wb_en_q, hold_wb_en_d;
  logic              hold_mem_read_q, hold_mem_read_d;
  logic [31:0]       hold_alu_q, hold_alu_d;
  logic [3:0]        hold_dest_q, hold_dest_d;

  logic [29:0] word_off;
  logic        mem_op;
  logic        drop_access;
  logic        freeze_c;

  assign word_off = word_offset(ALU_result_in, ADDR_BASE);
  assign mem_op   = mem_read_in | mem_write_in;

`ifdef MEM_RANGE_CHECK_EN
  assign drop_access = |word_off[29:ADDR_W];
`else
  assign drop_access = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    rdata_d         = rdata_q;
    hold_wb_en_d    = hold_wb_en_q;
    hold_mem_read_d = hold_mem_read_q;
    hold_alu_d      = hold_alu_q;
    hold_dest_d     = hold_dest_q;
    freeze_c        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          freeze_c        = 1'b1;
          hold_wb_en_d    = wb_en_in;
          hold_mem_read_d = mem_read_in;
          hold_alu_d      = ALU_result_in;
          hold_dest_d     = dest_in;
          rdata_d         = '0;
          if (drop_access) begin
            state_d = S_DONE;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = mem_write_in;
            mem_addr_d  = word_off[ADDR_W-1:0];
            mem_wdata_d = valRm_in;
            state_d     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        freeze_c = 1'b1;
        if (mem_ack) begin
          rdata_d   = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      rdata_q         <= '0;
      hold_wb_en_q    <= 1'b0;
      hold_mem_read_q <= 1'b0;
      hold_alu_q      <= '0;
      hold_dest_q     <= '0;
    end else begin
      state_q         <= state_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      rdata_q         <= rdata_d;
      hold_wb_en_q    <= hold_wb_en_d;
      hold_mem_read_q <= hold_mem_read_d;
      hold_alu_q      <= hold_alu_d;
      hold_dest_q     <= hold_dest_d;
    end
  end

  // Reset forces freeze low even while the inputs still show a memory op.
  assign freeze    = rst & freeze_c;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  logic        out_wb_en, out_mem_read;
  logic [31:0] out_alu, out_mem_data;
  logic [3:0]  out_dest;

  always_comb begin
    if (state_q == S_DONE) begin
      out_wb_en    = hold_wb_en_q;
      out_mem_read = hold_mem_read_q;
      out_alu      = hold_alu_q;
      out_dest     = hold_dest_q;
      out_mem_data = hold_mem_read_q ? rdata_q : '0;
    end else begin
      out_wb_en    = wb_en_in;
      out_mem_read = mem_read_in;
      out_alu      = ALU_result_in;
      out_dest     = dest_in;
      out_mem_data = '0;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (!freeze),
    .wb_en_in    (out_wb_en),
    .mem_read_in (out_mem_read),
    .alu_in      (out_alu),
    .mem_data_in (out_mem_data),
    .dest_in     (out_dest),
    .wb_en       (wb_en),
    .mem_read    (mem_read),
    .ALU_result  (ALU_result),
    .mem_data    (mem_data),
    .dest        (dest)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: transaction-level model plus an acking memory responder.
module tb_mem_stage;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          AW   = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_en_in, mem_read_in, mem_write_in;
  logic [31:0]   ALU_result_in, valRm_in;
  logic [3:0]    dest_in;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_ack;
  logic          freeze, wb_en, mem_read;
  logic [31:0]   ALU_result, mem_data;
  logic [3:0]    dest;

  int n_cmp = 0;
  int n_bad = 0;

  // phys_mem is the memory seen through the DUT's address; ref_mem is indexed by the expected address.
  logic [31:0] phys_mem [64];
  logic [31:0] ref_mem  [64];

  always #5 clk = ~clk;

  mem_stage #(.ADDR_BASE(BASE), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .ALU_result_in(ALU_result_in), .valRm_in(valRm_in), .dest_in(dest_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .freeze(freeze),
    .wb_en(wb_en), .mem_read(mem_read), .ALU_result(ALU_result),
    .mem_data(mem_data), .dest(dest)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_nonzero();
    return {31'd0, |{wb_en, mem_read, dest, ALU_result, mem_data}};
  endfunction

  // kind: 0 = ALU op, 1 = load, 2 = store. Called at a negedge; returns at a negedge.
  task automatic run_instr(input int kind, input logic wb, input logic [31:0] alu,
                           input logic [31:0] val, input logic [3:0] dst,
                           input int delay, input bit noise);
    logic [31:0] off;
    logic [31:0] exp_data;
    int          word;
    bit          is_mem, drop, done, prev_freeze, saw_req;
    int          exp_freeze, freeze_cnt, req_cycles;
    is_mem = (kind != 0);
    off    = alu - BASE;
    word   = int'((off / 32'd4) % 32'd64);
    drop   = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
    drop = is_mem && (off >= 32'd256);
`endif
    exp_data = (kind == 1 && !drop) ? ref_mem[word] : 32'd0;
    if (kind == 2 && !drop) ref_mem[word] = val;
    exp_freeze = !is_mem ? 0 : (drop ? 1 : 2 + delay);

    wb_en_in      = wb;
    mem_read_in   = (kind == 1);
    mem_write_in  = (kind == 2);
    ALU_result_in = alu;
    valRm_in      = val;
    dest_in       = dst;
    freeze_cnt = 0; req_cycles = 0; prev_freeze = 1'b0; done = 1'b0; saw_req = 1'b0;

    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (prev_freeze) check("bubble", outs_nonzero(), 32'd0);
      if (mem_req) begin
        saw_req = 1'b1;
        check("mem_addr", 32'(mem_addr), 32'(word));
        check("mem_we", 32'(mem_we), 32'(kind == 2));
        if (kind == 2) check("mem_wdata", mem_wdata, val);
        if (req_cycles == delay) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            phys_mem[mem_addr] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = phys_mem[mem_addr];
          end
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
        req_cycles++;
      end else begin
        mem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
      end
      #1;
      if (freeze) freeze_cnt++;
      done        = !freeze;
      prev_freeze = freeze;
      @(posedge clk);
      @(negedge clk);
    end
    mem_ack = 1'b0;

    if (!done) check("timeout", 32'd1, 32'd0);
    check("freeze_cycles", 32'(freeze_cnt), 32'(exp_freeze));
    check("req_issued", 32'(saw_req), 32'(is_mem && !drop));
    check("wb_en", 32'(wb_en), 32'(wb));
    check("mem_read", 32'(mem_read), 32'(kind == 1));
    check("ALU_result", ALU_result, alu);
    check("dest", 32'(dest), 32'(dst));
    check("mem_data", mem_data, exp_data);
    $display("txn kind=%0d alu=%h val=%h dest=%0d delay=%0d drop=%0d freeze=%0d -> mem_data=%h",
             kind, alu, val, dst, delay, drop, freeze_cnt, mem_data);
  endtask

  task automatic idle_inputs();
    wb_en_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    ALU_result_in = '0; valRm_in = '0; dest_in = '0;
  endtask

  initial begin
    int          kind, delay;
    logic [31:0] alu;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] v;
      v = $urandom;
      phys_mem[i] = v;
      ref_mem[i]  = v;
    end
    rst = 1'b0;
    idle_inputs();
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_freeze", 32'(freeze), 32'd0);
    check("rst_outputs", outs_nonzero(), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed: ADD, LDR with one extra wait, STR with immediate ack.
    run_instr(0, 1'b1, 32'h55, 32'h0, 4'd3, 0, 1'b0);
    phys_mem[1] = 32'hDEADBEEF;
    ref_mem[1]  = 32'hDEADBEEF;
    run_instr(1, 1'b1, 32'd1028, 32'h0, 4'd5, 1, 1'b0);
    run_instr(2, 1'b0, 32'd1032, 32'h12345678, 4'd0, 0, 1'b0);
    check("str_stored", ref_mem[2], 32'h12345678);
    // Just past the end of the memory: dropped with the range check, wraps to word 0 without it.
    run_instr(1, 1'b1, 32'd1280, 32'h0, 4'd7, 0, 1'b0);
    // Back-to-back loads followed by an ALU op.
    run_instr(1, 1'b1, 32'd1036, 32'h0, 4'd1, 2, 1'b1);
    run_instr(1, 1'b1, 32'd1032, 32'h0, 4'd2, 0, 1'b1);
    run_instr(0, 1'b1, 32'hCAFE0001, 32'h0, 4'd9, 0, 1'b1);

    // Reset in the middle of a wait, then a late ack after release.
    wb_en_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
    ALU_result_in = 32'd1040; dest_in = 4'd4;
    @(posedge clk);
    @(negedge clk);
    check("wait_req_high", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_wait_req", 32'(mem_req), 32'd0);
    check("rst_wait_freeze", 32'(freeze), 32'd0);
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_outputs", outs_nonzero(), 32'd0);
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_freeze", 32'(freeze), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("late_ack_outputs2", outs_nonzero(), 32'd0);

    // Randomized mix.
    for (int t = 0; t < 150; t++) begin
      kind  = $urandom_range(0, 2);
      delay = $urandom_range(0, 3);
      if (kind != 0 && ($urandom_range(0, 7) == 0)) alu = $urandom;
      else if (kind != 0) alu = BASE + $urandom_range(0, 255);
      else alu = $urandom;
      run_instr(kind, 1'($urandom_range(0, 1)), alu, $urandom, 4'($urandom_range(0, 15)),
                delay, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
